// File: rtl/uart_tx_fsm_if.sv
// uart_tx_fsm_if: byte handshake plus serial line and status for the UART transmitter.
// Latency: none; this is a wiring bundle only.
// Backpressure: the producer holds tx_valid and tx_data until it sees tx_ready.
interface uart_tx_fsm_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 txd;
    logic                 tx_busy;
    logic                 tx_done;

    // Producer side: offers bytes and watches the line and status.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  txd,
        input  tx_busy,
        input  tx_done
    );

    // Transmitter side: accepts bytes and drives the line and status.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output txd,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART serialiser, start / DATA_BITS LSB-first / optional parity / stop bits.
// Latency: start bit appears on txd the cycle after acceptance; frame = bits x CLKS_PER_BIT.
// Backpressure: tx_ready only in IDLE, so a new byte waits until the current frame ends.
// Build option: define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_fsm #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_fsm_if.slave tx_if
);

    // Elaboration-time guard on the legal parameter ranges.
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
        DATA_BITS < 5 || DATA_BITS > 8 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("uart_tx_fsm: parameter out of range");
    end

    // Last value of each counter, pre-sized to the counter widths.
    localparam logic [15:0] CNT_LAST      = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  IDX_LAST      = 3'(DATA_BITS - 1);
    localparam logic        STOP_IDX_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_ODD_BIT = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    state_t               state_q,    state_d;
    logic [15:0]          cnt_q,      cnt_d;
    logic [2:0]           bit_idx_q,  bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q,   parity_d;
`endif

    // Output registers; their next values are decoded from the next state so
    // every output lines up with the state it describes.
    logic txd_q,   txd_d;
    logic ready_q, ready_d;
    logic busy_q,  busy_d;
    logic done_q,  done_d;

    logic bit_end;
    logic accept;

    assign bit_end = (cnt_q == CNT_LAST);
    assign accept  = tx_if.tx_valid && ready_q;

    // State, counters, shift register and output registers; reset parks the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
            txd_q      <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
            txd_q      <= txd_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: bit timing, data shifting and frame sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
                if (accept) begin
                    // The byte is captured here; later changes on tx_data are ignored.
                    shift_d = tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_if.tx_data) ^ PAR_ODD_BIT;
`endif
                    state_d = START;
                end
            end

            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop_idx_q == STOP_IDX_LAST) begin
                        stop_idx_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs switch
    // on the same edge as the state they belong to.
    always_comb begin
        txd_d   = 1'b1;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        // Done marks the final cycle of the last stop bit.
        done_d  = (state_d == STOP) && (cnt_d == CNT_LAST) &&
                  (stop_idx_d == STOP_IDX_LAST);

        case (state_d)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = parity_d;
`endif
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
    end

    assign tx_if.txd      = txd_q;
    assign tx_if.tx_ready = ready_q;
    assign tx_if.tx_busy  = busy_q;
    assign tx_if.tx_done  = done_q;

endmodule

// File: doc/uart_tx_fsm.md
UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868: clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL provide parameter DATA_BITS, default 8: payload bits per frame; legal range 5..8.
REQ-003 SHALL provide parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-004 SHALL provide parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when parity is compiled in.
REQ-005 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port tx_data  input  DATA_BITS  byte to send; sampled only on acceptance.
REQ-008 SHALL have port tx_valid  input  1  tx_data is valid.
REQ-009 SHALL have port tx_ready  output  1  block can accept a byte.
REQ-010 SHALL have port txd  output  1  serial line; idle high.
REQ-011 SHALL have port tx_busy  output  1  frame in progress.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-014 SHALL hold tx_ready=1 only in IDLE; acceptance = tx_valid && tx_ready in the same cycle.
REQ-015 On acceptance in cycle N, SHALL latch tx_data into a shift register and enter START, driving txd=0 from cycle N+1.
REQ-016 SHALL hold every bit on txd for exactly CLKS_PER_BIT cycles, timed by an internal bit counter cleared on each state or bit change.
REQ-017 SHALL transmit data LSB first, DATA_BITS bits, tracking position with a bit index counter that wraps to 0 on leaving DATA.
REQ-018 Transitions SHALL be: START->DATA; DATA->PARITY after the last data bit when parity is compiled in, otherwise DATA->STOP; PARITY->STOP; STOP->IDLE after STOP_BITS stop bits.
REQ-019 SHALL drive txd=1 in IDLE and STOP.
REQ-020 SHALL assert tx_busy in every state except IDLE.
REQ-021 SHALL pulse tx_done for exactly one cycle, coinciding with the last clk cycle of the final stop bit; tx_ready SHALL rise on the next cycle.
REQ-022 tx_valid held high continuously SHALL give back-to-back frames, separated by exactly one IDLE cycle of txd=1.
REQ-023 Changes on tx_data or tx_valid while tx_busy=1 SHALL have no effect on the frame in flight.
REQ-024 Frame length SHALL be (1 + DATA_BITS + P + STOP_BITS) x CLKS_PER_BIT cycles, where P = 1 with parity compiled in and 0 without.

Reset
REQ-025 Asserting rst SHALL immediately force state=IDLE, txd=1, tx_ready=0, tx_busy=0, tx_done=0, and clear all counters and the shift register.
REQ-026 SHALL drive tx_ready=1 from the first clk edge after rst deasserts.
REQ-027 Reset mid-frame SHALL abort the frame, emit no tx_done, and leave txd high with no glitch low.

Configuration
REQ-028 With UART_TX_PARITY_EN defined, SHALL insert one parity bit after the data bits: XOR of the data bits for even parity, its inverse when PARITY_ODD=1.
REQ-029 With UART_TX_PARITY_EN undefined, SHALL omit the PARITY state and its logic entirely, and SHALL ignore PARITY_ODD.

Verification
REQ-030 CLKS_PER_BIT=4, parity off, send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx_done pulse at cycle 40 after acceptance.
REQ-031 UART_TX_PARITY_EN, PARITY_ODD=0, send 0xA5 -> parity bit 0; PARITY_ODD=1 -> parity bit 1; frame = 44 cycles.
REQ-032 tx_valid held high with 0x00 then 0xFF -> two frames separated by exactly 1 idle cycle; tx_ready high for exactly 1 cycle between the frames.
REQ-033 rst pulsed during data bit 3 -> txd=1 and tx_busy=0 immediately; no tx_done; a new 0x3C is accepted the cycle after reset release.
REQ-034 STOP_BITS=2, send 0x55 -> stop high for 8 cycles (CLKS_PER_BIT=4); tx_data toggled mid-frame -> serial output unchanged.
